// File: rtl/scie_fir_pipelined.sv
// scie_fir_pipelined: 32-tap FIR behind a SCIE-style custom-instruction port (LOADC/PUSH/READ).
// Optional FIR_CLEAR_EN adds a CLEAR opcode (0x5B) that zeroes the delay line and accumulator.
module scie_fir_pipelined #(
  parameter int XLEN = 32,
  parameter int TAPS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd
);
  localparam int IDXW = $clog2(TAPS);
  localparam logic [6:0] OP_LOADC = 7'h0B;
  localparam logic [6:0] OP_PUSH  = 7'h2B;
  localparam logic [6:0] OP_READ  = 7'h3B;
  logic [XLEN-1:0] coeff_q [TAPS];
  logic [XLEN-1:0] x_q [TAPS];
  logic [XLEN-1:0] acc_q, acc_d, rd_q;
  logic [6:0] op;
  logic       do_load, do_push, do_read, do_clr;
  logic       unused_bits;
  assign op      = io_insn[6:0];
  assign do_load = io_valid && op == OP_LOADC;
  assign do_push = io_valid && op == OP_PUSH;
  assign do_read = io_valid && op == OP_READ;
`ifdef FIR_CLEAR_EN
  assign do_clr  = io_valid && op == 7'h5B;
`else
  assign do_clr  = 1'b0;
`endif
  assign unused_bits = ^{io_insn[31:7], io_rs2[XLEN-1:IDXW]};
  // Products and sum wrap to XLEN bits, so signedness does not matter.
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < TAPS; k++) acc_d = acc_d + coeff_q[k] * x_q[k];
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        coeff_q[k] <= '0;
        x_q[k]     <= '0;
      end
      acc_q <= '0;
      rd_q  <= '0;
    end else begin
      acc_q <= do_clr ? '0 : acc_d;
      if (do_read) rd_q <= acc_q;
      if (do_load) coeff_q[io_rs2[IDXW-1:0]] <= io_rs1;
      if (do_push) begin
        x_q[0] <= io_rs1;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end else if (do_clr) begin
        for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      end
    end
  end
  assign io_rd = rd_q;
endmodule

// File: tb/tb_scie_fir_pipelined.sv
// tb_scie_fir_pipelined: directed spec vectors plus random commands against a behavioural model.
module tb_scie_fir_pipelined;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_valid = 1'b0;
  logic [31:0] io_insn = '0, io_rs1 = '0, io_rs2 = '0;
  logic [31:0] io_rd;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mc [32];
  logic [31:0] mx [32];
  logic [31:0] macc, mrd;
  int coeffs [32] = '{36,64,76,16,88,26,30,63,86,65,61,43,18,74,79,96,
                      65,37,78,46,55,70,16,3,70,60,24,21,2,88,72,63};
  int pushes [6]  = '{85,63,99,12,36,93};
  int results [6] = '{3060,7708,14056,12916,18076,15902};
  logic [6:0] ops [5] = '{7'h0B, 7'h2B, 7'h3B, 7'h13, 7'h5B};

  scie_fir_pipelined dut (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_insn(io_insn),
    .io_rs1(io_rs1), .io_rs2(io_rs2), .io_rd(io_rd)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dot();
    logic [31:0] s = '0;
    for (int k = 0; k < 32; k++) s = s + mc[k] * mx[k];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge: drive at negedge, update the model at posedge, compare io_rd just after.
  task automatic cyc(input logic v, input logic [6:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic rst_n = 1'b1);
    logic [31:0] nacc;
    @(negedge clock);
    reset = rst_n; io_valid = v; io_insn = {25'($urandom), op}; io_rs1 = a; io_rs2 = b;
    @(posedge clock);
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin mc[k] = '0; mx[k] = '0; end
      macc = '0; mrd = '0;
    end else begin
      nacc = dot();
      if (v) begin
        if (op == 7'h0B) mc[b % 32] = a;
        if (op == 7'h2B) begin
          for (int k = 31; k > 0; k--) mx[k] = mx[k-1];
          mx[0] = a;
        end
        if (op == 7'h3B) mrd = macc;
`ifdef FIR_CLEAR_EN
        if (op == 7'h5B) begin
          for (int k = 0; k < 32; k++) mx[k] = '0;
          nacc = '0;
        end
`endif
      end
      macc = nacc;
    end
    #1 chk("model", io_rd, mrd);
  endtask

  initial begin
    cyc(1'b0, 7'h00, 0, 0, 1'b0);
    cyc(1'b1, 7'h3B, 0, 0, 1'b0);
    chk("reset_rd", io_rd, 32'd0);
    for (int i = 0; i < 32; i++) cyc(1'b1, 7'h0B, 32'(coeffs[i]), 32'(i));
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 7'h2B, 32'(pushes[i]), 0);
      cyc(1'b0, 7'h00, 0, 0);
      cyc(1'b1, 7'h3B, 0, 0);
      chk($sformatf("push_%0d", pushes[i]), io_rd, 32'(results[i]));
    end
    cyc(1'b1, 7'h2B, 32'd24, 0);
    cyc(1'b1, 7'h3B, 0, 0);
    chk("read_early", io_rd, 32'd15902);
    cyc(1'b1, 7'h3B, 0, 0);
    chk("read_late", io_rd, 32'd22644);
    cyc(1'b0, 7'h2B, 32'd50, 0);
    cyc(1'b0, 7'h00, 0, 0);
    cyc(1'b1, 7'h3B, 0, 0);
    chk("invalid_push", io_rd, 32'd22644);
    cyc(1'b1, 7'h13, $urandom, $urandom);
    chk("unknown_hold", io_rd, 32'd22644);
    cyc(1'b1, 7'h0B, 32'd5, 32'd32);
    cyc(1'b0, 7'h00, 0, 0);
    chk("loadc_hold", io_rd, 32'd22644);
    cyc(1'b1, 7'h3B, 0, 0);
    chk("wrap_idx", io_rd, 32'd22644 - 36*24 + 5*24);
    cyc(1'b1, 7'h2B, 32'd7, 0, 1'b0);
    chk("mid_reset", io_rd, 32'd0);
    cyc(1'b1, 7'h2B, 32'd85, 0);
    cyc(1'b0, 7'h00, 0, 0);
    cyc(1'b1, 7'h3B, 0, 0);
    chk("post_reset", io_rd, 32'd0);
    for (int i = 0; i < 32; i++) cyc(1'b1, 7'h0B, $urandom, 32'(i));
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 4)], $urandom, $urandom,
          1'($urandom_range(0, 199) != 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
